// File: rtl/sma_dual_window.sv
// Dual-window running-sum moving averages over a ring buffer of recent prices.
// Short and long SMAs, plus the aligned sample, are registered one cycle after each accepted price.
module sma_dual_window #(
  parameter int data_width = 16,
  parameter int short_log2 = 2,
  parameter int long_log2  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  price_valid,
  input  logic [data_width-1:0] price,
  output logic [data_width-1:0] short_sma,
  output logic [data_width-1:0] long_sma,
  output logic [data_width-1:0] current_data,
  output logic                  data_valid_pre,
  output logic                  warm
);

  localparam int nl = 1 << long_log2;
  localparam int sw = data_width + short_log2;
  localparam int lw = data_width + long_log2;
  localparam logic [long_log2:0]   cnt_full = (long_log2 + 1)'(nl);
  localparam logic [long_log2-1:0] ns_off   = long_log2'(1 << short_log2);

  logic [data_width-1:0] mem [nl];
  logic [long_log2-1:0]  wptr;
  logic [long_log2-1:0]  short_idx;
  logic [long_log2:0]    cnt;
  logic [long_log2:0]    cnt_next;
  logic [sw-1:0]         short_sum;
  logic [sw-1:0]         short_next;
  logic [lw-1:0]         long_sum;
  logic [lw-1:0]         long_next;
  logic [data_width-1:0] short_out;
  logic [data_width-1:0] long_out;
  logic                  accept;

  // Samples leaving each window; entries not yet written since a flush read as zero.
  always_comb begin
    accept     = price_valid && !clear && !rst;
    short_idx  = wptr - ns_off;
    long_out   = (cnt == cnt_full) ? mem[wptr] : '0;
    short_out  = (|cnt[long_log2:short_log2]) ? mem[short_idx] : '0;
    short_next = short_sum + sw'(price) - sw'(short_out);
    long_next  = long_sum + lw'(price) - lw'(long_out);
    cnt_next   = (cnt == cnt_full) ? cnt : cnt + (long_log2 + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= price;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr           <= '0;
      cnt            <= '0;
      short_sum      <= '0;
      long_sum       <= '0;
      short_sma      <= '0;
      long_sma       <= '0;
      current_data   <= '0;
      data_valid_pre <= 1'b0;
      warm           <= 1'b0;
    end else begin
      data_valid_pre <= 1'b0;
      if (price_valid) begin
        wptr           <= wptr + long_log2'(1);
        cnt            <= cnt_next;
        short_sum      <= short_next;
        long_sum       <= long_next;
        // Outputs come from the post-update sums so they include this sample.
        short_sma      <= short_next[sw-1:short_log2];
        long_sma       <= long_next[lw-1:long_log2];
        current_data   <= price;
        data_valid_pre <= (cnt_next == cnt_full);
        warm           <= (cnt_next == cnt_full);
      end
    end
  end

endmodule

// File: tb/tb_sma_dual_window.sv
// Self-checking bench for sma_dual_window: a directed vector table plus
// multi-cycle sequences checked against a direct window-sum reference.
module tb_sma_dual_window;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        price_valid = 1'b0;
  logic [15:0] price = '0;
  logic [15:0] short_sma, long_sma, current_data;
  logic        data_valid_pre, warm;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sma_dual_window dut (
    .clk(clk), .rst(rst), .clear(clear), .price_valid(price_valid), .price(price),
    .short_sma(short_sma), .long_sma(long_sma), .current_data(current_data),
    .data_valid_pre(data_valid_pre), .warm(warm)
  );

  typedef struct {
    logic        v;
    logic        c;
    logic [15:0] p;
    logic        e_dv;
    logic [15:0] e_s;
    logic [15:0] e_l;
    logic [15:0] e_cur;
    logic        e_w;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(int v, int c, int p, int dv, int s, int l, int cur, int w);
    vec_t r;
    r.v = v[0]; r.c = c[0]; r.p = p[15:0]; r.e_dv = dv[0];
    r.e_s = s[15:0]; r.e_l = l[15:0]; r.e_cur = cur[15:0]; r.e_w = w[0];
    return r;
  endfunction

  // Reference state: accepted samples since the last flush, newest at the back.
  int          hist [$];
  logic        m_dv, m_w;
  logic [15:0] m_s, m_l, m_cur;

  task automatic model_flush();
    hist.delete();
    m_dv = 0; m_w = 0; m_s = 0; m_l = 0; m_cur = 0;
  endtask

  task automatic model_step(input logic v, input logic c, input logic [15:0] p);
    longint ss, ls;
    if (c) begin
      model_flush();
    end else if (v) begin
      hist.push_back(int'(p));
      if (hist.size() > 16) void'(hist.pop_front());
      ss = 0; ls = 0;
      foreach (hist[i]) begin
        ls += hist[i];
        if (i >= hist.size() - 4) ss += hist[i];
      end
      m_s = 16'(ss / 4);
      m_l = 16'(ls / 16);
      m_cur = p;
      m_dv = (hist.size() == 16);
      m_w = (hist.size() == 16);
    end else begin
      m_dv = 0;
    end
  endtask

  task automatic check_output(input string name, input logic dv, input logic [15:0] s,
                              input logic [15:0] l, input logic [15:0] cur, input logic w);
    tests_run++;
    if (data_valid_pre !== dv || short_sma !== s || long_sma !== l ||
        current_data !== cur || warm !== w) begin
      tests_failed++;
      $display("[TB] FAIL %s: got dv=%0d short=%0d long=%0d cur=%0d warm=%0d, expected dv=%0d short=%0d long=%0d cur=%0d warm=%0d",
               name, data_valid_pre, short_sma, long_sma, current_data, warm, dv, s, l, cur, w);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic c, input logic [15:0] p);
    @(negedge clk);
    price_valid = v; clear = c; price = p;
    @(posedge clk);
    #1;
  endtask

  task automatic run_model(input string name, input logic v, input logic c, input logic [15:0] p);
    apply_stimulus(v, c, p);
    model_step(v, c, p);
    check_output(name, m_dv, m_s, m_l, m_cur, m_w);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1; price_valid = 1'b1; clear = 1'b0; price = 16'd777;
    @(posedge clk);
    #1;
    model_flush();
    check_output(name, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; price_valid = 1'b0;
  endtask

  initial begin
    // Ramp 1..16, idle, one more, then a flush that drops a coincident sample.
    tbl[0]  = mk(1,0, 1, 0, 0,0, 1,0);
    tbl[1]  = mk(1,0, 2, 0, 0,0, 2,0);
    tbl[2]  = mk(1,0, 3, 0, 1,0, 3,0);
    tbl[3]  = mk(1,0, 4, 0, 2,0, 4,0);
    tbl[4]  = mk(1,0, 5, 0, 3,0, 5,0);
    tbl[5]  = mk(1,0, 6, 0, 4,1, 6,0);
    tbl[6]  = mk(1,0, 7, 0, 5,1, 7,0);
    tbl[7]  = mk(1,0, 8, 0, 6,2, 8,0);
    tbl[8]  = mk(1,0, 9, 0, 7,2, 9,0);
    tbl[9]  = mk(1,0,10, 0, 8,3,10,0);
    tbl[10] = mk(1,0,11, 0, 9,4,11,0);
    tbl[11] = mk(1,0,12, 0,10,4,12,0);
    tbl[12] = mk(1,0,13, 0,11,5,13,0);
    tbl[13] = mk(1,0,14, 0,12,6,14,0);
    tbl[14] = mk(1,0,15, 0,13,7,15,0);
    tbl[15] = mk(1,0,16, 1,14,8,16,1);
    tbl[16] = mk(0,0, 0, 0,14,8,16,1);
    tbl[17] = mk(1,0,17, 1,15,9,17,1);
    tbl[18] = mk(1,1,99, 0, 0,0, 0,0);
    tbl[19] = mk(0,0, 0, 0, 0,0, 0,0);
    tbl[20] = mk(1,0, 5, 0, 1,0, 5,0);

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply_stimulus(tbl[i].v, tbl[i].c, tbl[i].p);
      check_output($sformatf("table_%0d", i), tbl[i].e_dv, tbl[i].e_s, tbl[i].e_l,
                   tbl[i].e_cur, tbl[i].e_w);
    end

    // Constant 100, then 200s entering the window, then random samples across many wraps.
    do_reset("reset_before_const");
    for (int i = 0; i < 16; i++) run_model($sformatf("const100_%0d", i), 1, 0, 16'd100);
    check_output("const100_final", 1, 100, 100, 100, 1);
    for (int i = 0; i < 4; i++) run_model($sformatf("step200_%0d", i), 1, 0, 16'd200);
    check_output("step200_final", 1, 200, 125, 200, 1);
    for (int i = 0; i < 40; i++)
      run_model($sformatf("random_%0d", i), 1, 0, 16'($urandom_range(0, 65535)));

    // Full-scale samples must not overflow either sum.
    do_reset("reset_before_max");
    for (int i = 0; i < 20; i++) run_model($sformatf("max_%0d", i), 1, 0, 16'hFFFF);
    check_output("max_final", 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1);
    for (int i = 0; i < 16; i++) run_model($sformatf("zero_%0d", i), 1, 0, 16'd0);
    check_output("zero_final", 1, 0, 0, 0, 1);

    // Sparse ramp: one sample every third cycle, outputs must hold in the gaps.
    do_reset("reset_before_sparse");
    for (int i = 1; i <= 16; i++) begin
      run_model($sformatf("sparse_acc_%0d", i), 1, 0, 16'(i));
      if (i == 16) check_output("sparse_strobe", 1, 14, 8, 16, 1);
      run_model($sformatf("sparse_gap_a_%0d", i), 0, 0, 16'hBEEF);
      run_model($sformatf("sparse_gap_b_%0d", i), 0, 0, 16'hBEEF);
    end
    check_output("sparse_hold", 0, 14, 8, 16, 1);

    // rst mid-ramp, then fresh data must warm up over a full long window again.
    for (int i = 1; i <= 10; i++) run_model($sformatf("pre_rst_%0d", i), 1, 0, 16'(i));
    do_reset("rst_mid_stream");
    for (int i = 0; i < 16; i++) run_model($sformatf("post_rst_%0d", i), 1, 0, 16'(50 + i));
    check_output("post_rst_strobe", 1, 63, 57, 65, 1);

    // clear mid-ramp with a coincident valid sample that must be dropped.
    for (int i = 1; i <= 10; i++) run_model($sformatf("pre_clr_%0d", i), 1, 0, 16'(i));
    run_model("clear_with_valid", 1, 1, 16'd999);
    check_output("clear_outputs", 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) run_model($sformatf("post_clr_%0d", i), 1, 0, 16'(200 + 2 * i));
    check_output("post_clr_strobe", 1, 227, 215, 230, 1);
    run_model("post_clr_idle", 0, 0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
